// File: rtl/et_sng_if.sv
// -----------------------------------------------------------------------------
// et_sng_if -- operand/stream/status bundle for the early-termination SNG.
//
// Signal summary (directions seen from the et_sng slave):
//   in_valid  in   operand Bx/z valid
//   in_ready  out  generator idle, operand will be taken
//   Bx        in   [WIDTH-1:0] binary operand
//   z         in   [WIDTH-1:0] prefix-OR mask from the trailing-zero stage
//   out_valid out  out_bit valid
//   out_ready in   consumer takes out_bit
//   out_bit   out  stochastic stream bit
//   out_last  out  final bit of the stream
//   done      out  one-cycle pulse after the last bit handshake
//   len       out  [WIDTH:0] stream length 2^m, valid with done
//   ones      out  [WIDTH:0] ones emitted, valid with done
//   err       out  sticky: a non-thermometer z was accepted
// -----------------------------------------------------------------------------
interface et_sng_if #(
  parameter int WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] Bx;
  logic [WIDTH-1:0] z;
  logic             out_valid;
  logic             out_ready;
  logic             out_bit;
  logic             out_last;
  logic             done;
  logic [WIDTH:0]   len;
  logic [WIDTH:0]   ones;
  logic             err;

  // Upstream stage + consumer side.
  modport master (
    output in_valid, Bx, z, out_ready,
    input  in_ready, out_valid, out_bit, out_last, done, len, ones, err
  );

  // Generator side.
  modport slave (
    input  in_valid, Bx, z, out_ready,
    output in_ready, out_valid, out_bit, out_last, done, len, ones, err
  );

endinterface

// File: rtl/et_sng.sv
// -----------------------------------------------------------------------------
// et_sng -- early-termination stochastic number generator.
//
// Takes operand Bx and the prefix-OR mask z (m = popcount(z)) and emits a
// unipolar bitstream of probability Bx/2^WIDTH by comparing Bx against a
// bit-reversed counter. The stream stops after exactly 2^m bits, the shortest
// length that represents Bx exactly, then pulses done with len and ones.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous reset, active-high
//   bus  et_sng_if.slave (operand handshake, stream handshake, status)
// -----------------------------------------------------------------------------
module et_sng #(
  parameter int WIDTH = 8
) (
  input  logic    clk,
  input  logic    rst,
  et_sng_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_bx;
  logic [WIDTH-1:0] r_z;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH:0]   r_ones;
  logic             r_err;

  logic [WIDTH-1:0] w_cnt_rev;
  logic [WIDTH-1:0] w_lenmask;
  logic [WIDTH-1:0] w_z_inv;
  logic [WIDTH-1:0] w_z_inv_inc;
  logic             w_z_legal;
  logic             w_bit;
  logic             w_last;
  logic             w_streaming;
  logic             w_done;
  logic [WIDTH:0]   w_len;

  // Bit reversal is pure wiring: the reversed counter sweeps thresholds in
  // van der Corput order, and the reversed thermometer mask becomes 2^m-1.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
    assign w_cnt_rev[gi] = r_cnt[WIDTH-1-gi];
    assign w_lenmask[gi] = r_z[WIDTH-1-gi];
  end

  // A legal z is ones from some bit up to the MSB (or all zeros), so ~z is
  // of the form 2^j-1; such a value has no bit in common with its successor.
  assign w_z_inv     = ~bus.z;
  assign w_z_inv_inc = w_z_inv + WIDTH'(1);
  assign w_z_legal   = ((w_z_inv & w_z_inv_inc) == '0);

  assign w_bit       = (r_bx > w_cnt_rev);
  assign w_last      = (r_cnt == w_lenmask);
  assign w_streaming = (r_state == S_STREAM);
  assign w_len       = {1'b0, w_lenmask} + (WIDTH+1)'(1);

  // NOTE: continuous assigns (and fully defaulted combinational logic) can
  // never infer a latch; every output below has a value on every path.
  // Outputs are gated by rst so a mid-stream reset silences them at once.
  assign w_done        = !rst && (r_state == S_DONE);
  assign bus.in_ready  = !rst && (r_state == S_IDLE);
  assign bus.out_valid = !rst && w_streaming;
  assign bus.out_bit   = bus.out_valid && w_bit;
  assign bus.out_last  = bus.out_valid && w_last;
  assign bus.done      = w_done;
  assign bus.len       = w_done ? w_len  : '0;
  assign bus.ones      = w_done ? r_ones : '0;
  assign bus.err       = !rst && r_err;

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_bx    <= '0;
      r_z     <= '0;
      r_cnt   <= '0;
      r_ones  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_bx    <= bus.Bx;
            // An illegal mask runs the full 2^WIDTH-bit stream.
            r_z     <= w_z_legal ? bus.z : '1;
            r_cnt   <= '0;
            r_ones  <= '0;
            r_state <= S_STREAM;
            if (!w_z_legal) r_err <= 1'b1;
          end
        end
        S_STREAM: begin
          if (bus.out_ready) begin
            r_ones <= r_ones + (WIDTH+1)'(w_bit);
            // cnt stops at lenmask, so it never wraps even for m = WIDTH.
            if (w_last) r_state <= S_DONE;
            else        r_cnt   <= r_cnt + WIDTH'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_et_sng.sv
module tb_et_sng;

  localparam int W = 8;

  typedef struct {
    logic [7:0]  bx;
    logic [7:0]  z;
    int          stall_at;   // handshake count at which to stall, -1 = never
    int          stall_n;    // cycles of out_ready=0
    int          exp_len;
    int          exp_ones;
    bit          exp_err;
    bit          chk_pat;
    logic [15:0] exp_pat;    // bit i = i-th stream bit
    bit          chk_lat;
  } vec_t;

  typedef struct {
    int len;
    int ones;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic [1:0] q_bits[$];   // {last, bit}
  res_t       q_res[$];

  et_sng_if #(.WIDTH(W)) bus ();

  et_sng #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] a);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = a[7-i];
    return r;
  endfunction

  // Stream length from the mask: thermometer masks give 2^popcount,
  // anything else runs the full 256 bits.
  function automatic int model_len(input logic [7:0] zz);
    logic [7:0] t;
    if (zz == 8'h00) return 1;
    for (int j = 0; j < 8; j++) begin
      t = 8'hFF << j;
      if (zz == t) return 1 << (8 - j);
    end
    return 256;
  endfunction

  task automatic run_op(input vec_t v);
    int          n_exp;
    int          hs;
    int          stall_rem;
    int          budget;
    int          acc_cyc;
    logic [15:0] pat;
    logic [1:0]  exp_b;
    bit          got_done;
    res_t        r;

    n_exp = model_len(v.z);
    for (int i = 0; i < n_exp; i++)
      q_bits.push_back({(i == n_exp - 1), (v.bx > rev8(8'(i)))});
    q_res.push_back('{v.exp_len, v.exp_ones});

    bus.Bx        = v.bx;
    bus.z         = v.z;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    budget = 0;
    while (!bus.in_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check("accept_wait", 32'(budget < 20), 32'd1);
    @(negedge clk);
    acc_cyc = cyc;
    bus.in_valid = 1'b0;

    hs = 0;
    stall_rem = v.stall_n;
    pat = '0;
    got_done = 1'b0;
    budget = 0;
    while (!got_done && budget < 400) begin
      if (bus.done) begin
        got_done = 1'b1;
        r = q_res.pop_front();
        check("len",       32'(bus.len),  32'(r.len));
        check("ones",      32'(bus.ones), 32'(r.ones));
        check("err",       32'(bus.err),  32'(v.exp_err));
        check("nbits",     32'(hs),       32'(v.exp_len));
        check("bits_left", 32'(q_bits.size()), 32'd0);
        if (v.chk_pat) check("pattern", 32'(pat), 32'(v.exp_pat));
        if (v.chk_lat) check("latency", 32'(cyc - acc_cyc + 1), 32'd257);
      end else if (bus.out_valid) begin
        if (hs == v.stall_at && stall_rem > 0) begin
          bus.out_ready = 1'b0;
          stall_rem--;
        end else begin
          bus.out_ready = 1'b1;
        end
        if (q_bits.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_empty: extra bit %0b, no expected bit left", bus.out_bit);
        end else begin
          exp_b = q_bits[0];
          check("out_bit",  32'(bus.out_bit),  32'(exp_b[0]));
          check("out_last", 32'(bus.out_last), 32'(exp_b[1]));
          if (bus.out_ready) begin
            void'(q_bits.pop_front());
            if (hs < 16) pat[hs] = bus.out_bit;
            hs++;
          end
        end
      end
      @(negedge clk);
      budget++;
    end
    if (!got_done) begin
      total++;
      bad++;
      $display("FAIL done_timeout: no done after %0d cycles, want one", budget);
      q_bits.delete();
      q_res.delete();
    end
    bus.out_ready = 1'b1;
    // done must be a single cycle, followed by IDLE.
    check("done_pulse", 32'(bus.done),     32'd0);
    check("idle_ready", 32'(bus.in_ready), 32'd1);
    check("idle_len",   32'(bus.len),      32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'h60, 8'hE0, -1, 0,   8,  3, 1'b0, 1'b1, 16'h0015, 1'b0};
    vecs[1] = '{8'h80, 8'h80, -1, 0,   2,  1, 1'b0, 1'b1, 16'h0001, 1'b0};
    vecs[2] = '{8'h00, 8'h00, -1, 0,   1,  0, 1'b0, 1'b1, 16'h0000, 1'b0};
    vecs[3] = '{8'h03, 8'hFF, -1, 0, 256,  3, 1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[4] = '{8'h60, 8'hE0,  4, 3,   8,  3, 1'b0, 1'b1, 16'h0015, 1'b0};
    vecs[5] = '{8'h10, 8'h5A, -1, 0, 256, 16, 1'b1, 1'b0, 16'h0000, 1'b0};

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.Bx        = '0;
    bus.z         = '0;
    bus.out_ready = 1'b1;

    @(negedge clk);
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_bit",   32'(bus.out_bit),   32'd0);
    check("rst_done",      32'(bus.done),      32'd0);
    check("rst_len",       32'(bus.len),       32'd0);
    check("rst_ones",      32'(bus.ones),      32'd0);
    check("rst_err",       32'(bus.err),       32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 6; i++) run_op(vecs[i]);

    // Second operand after the illegal one, then reset mid-stream.
    bus.Bx = 8'h40;
    bus.z  = 8'hC0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_valid",   32'(bus.out_valid), 32'd1);
    check("err_sticky",  32'(bus.err),       32'd1);
    rst = 1'b1;
    #1;
    check("rst_now_valid", 32'(bus.out_valid), 32'd0);
    check("rst_now_err",   32'(bus.err),       32'd0);
    @(negedge clk);
    check("abort_valid", 32'(bus.out_valid), 32'd0);
    check("abort_ready", 32'(bus.in_ready),  32'd0);
    check("abort_done",  32'(bus.done),      32'd0);
    check("abort_err",   32'(bus.err),       32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("after_ready", 32'(bus.in_ready),  32'd1);
    check("after_valid", 32'(bus.out_valid), 32'd0);
    check("after_bit",   32'(bus.out_bit),   32'd0);
    check("after_err",   32'(bus.err),       32'd0);
    check("after_done",  32'(bus.done),      32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/et_sng.md
Name: et_sng

Overview:
- Early-termination stochastic number generator that sits directly downstream of the trailing-zero prefix-OR stage.
- It takes a binary operand Bx and the stage's prefix-OR mask z, and emits a unipolar bitstream of probability Bx/2^WIDTH.
- It compares Bx against a bit-reversed counter and stops after exactly 2^m cycles, where m = popcount(z). That is the shortest length that represents Bx exactly.
- On termination it reports the stream length and the emitted ones count to the SC datapath and the ET controller.

Parameters:
- WIDTH, 8, operand width in bits. Legal range 2..16.

Ports:
- clk       input   1          rising-edge clock
- rst       input   1          synchronous reset, active-high
- in_valid  input   1          Bx and z are valid
- in_ready  output  1          block can accept a new operand
- Bx        input   WIDTH      binary operand
- z         input   WIDTH      prefix-OR mask from the upstream stage
- out_valid output  1          out_bit is valid
- out_ready input   1          consumer accepts out_bit
- out_bit   output  1          stochastic stream bit
- out_last  output  1          marks the final bit of the stream
- done      output  1          one-cycle pulse after the last bit handshake
- len       output  WIDTH+1    stream length (2^m); valid while done=1
- ones      output  WIDTH+1    count of ones emitted; valid while done=1
- err       output  1          sticky flag: a non-thermometer z was accepted

Behaviour:
- Reset:
  - All outputs are 0 and the state is IDLE.
  - The counter, ones count and latched operands are 0.
  - in_ready is 0 during the reset cycle.
  - Reset mid-stream aborts the stream immediately with no done pulse, and clears err.
- State IDLE:
  - in_ready=1.
  - When in_valid=1 at a clock edge, latch Bx into bx_r and z into z_r, clear cnt and ones_r, then go to STREAM.
- State STREAM:
  - in_ready=0, out_valid=1.
  - out_bit = (bx_r > bitrev(cnt)), an unsigned WIDTH-bit comparison where bitrev reverses the bit order of cnt.
  - lenmask = bitrev(z_r), so a legal z yields lenmask = 2^m - 1.
  - out_last = (cnt == lenmask).
  - On each edge with out_valid and out_ready both 1:
    - ones_r += out_bit.
    - If out_last=1, go to DONE; otherwise cnt += 1.
  - Backpressure: while out_ready=0, cnt, out_bit and out_last hold stable.
- State DONE, lasting exactly one cycle:
  - done=1, len = lenmask + 1 computed at WIDTH+1 bits, ones = ones_r.
  - out_valid=0, in_ready=0. Next state is IDLE.
- Outputs out_bit, out_last, len and ones read 0 whenever their qualifier (out_valid or done) is 0.
- Legal z is either all zeros or ones from bit j up to bit WIDTH-1 with zeros below.
  - z = 0 (Bx = 0) gives m=0: a single cycle with out_bit=0 and out_last=1, then len=1 and ones=0.
  - The largest legal case, m=WIDTH, gives len = 2^WIDTH. cnt is WIDTH bits wide and never wraps, because last fires at cnt = 2^WIDTH - 1.
- Illegal z (not a thermometer of that form):
  - It is still accepted, err is set and held until reset.
  - z_r is forced to all ones, so the stream runs the full 2^WIDTH cycles.
- Exactness: for legal inputs, ones == Bx >> (WIDTH-m).
- Latency: the first bit is valid the cycle after acceptance. Back-to-back operands have a minimum spacing of len+2 cycles.
- in_valid asserted outside IDLE is ignored; the upstream stage must hold it until in_ready.

Test Plan (WIDTH=8):
- Bx=0x60, z=0xE0 -> 8 bits 1,0,1,0,1,0,0,0; out_last on the 8th bit; done with len=8, ones=3.
- Bx=0x80, z=0x80 -> bits 1,0; len=2, ones=1.
- Bx=0x00, z=0x00 -> one bit of 0 with out_last=1; len=1, ones=0.
- Bx=0x03, z=0xFF with out_ready held at 1 -> 256 bits; len=256, ones=3; done lands exactly 257 cycles after acceptance.
- Bx=0x60, z=0xE0 with out_ready=0 for 3 cycles after the 4th bit -> out_bit=1 and out_last=0 held stable; the stream otherwise matches the first scenario and ones=3.
- Bx=0x10, z=0x5A -> err=1 sticky, 256 bits, ones=16. Then assert rst mid-stream -> all outputs 0, err=0, in_ready=1 on the cycle after reset deasserts.
